// File: rtl/sumrest_flags_pipe.sv
// sumrest_flags_pipe
// Registered WIDTH-bit add/subtract and AND/OR unit with Cero/Negativo/C_out/
// Overflow flags, a single output stage behind a valid/ready handshake, an
// accumulator operand source, sticky carry/overflow status and a saturating
// overflow-event counter.
module sumrest_flags_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Resta,
    input  logic             OP1,
    input  logic             Acc_en,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cero,
    output logic             Negativo,
    output logic             C_out,
    output logic             Overflow,
    output logic             sticky_ovf,
    output logic             sticky_cout,
    output logic [CNT_W-1:0] ovf_count
);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             cero_q,     cero_d;
    logic             neg_q,      neg_d;
    logic             cout_q,     cout_d;
    logic             ovf_q,      ovf_d;
    logic             valid_q,    valid_d;
    logic             sovf_q,     sovf_d;
    logic             scout_q,    scout_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // ------------------------------------------------------------------
    // Operand selection and handshake
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] b_eff;
    logic             accept;

    assign x_op     = Acc_en ? acc_q : A;
    // Subtraction is X + ~B + 1: invert B here, the +1 enters as carry-in.
    assign b_eff    = B ^ {WIDTH{Resta}};
    // The output stage can take a new command when empty or being drained.
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Ripple-carry adder; the explicit chain exposes the carry into the MSB
    // needed for signed overflow.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Resta;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
            assign sum[gi]       = x_op[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi + 1] = (x_op[gi] & b_eff[gi])
                                 | (carry[gi] & (x_op[gi] ^ b_eff[gi]));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Logic unit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] logic_res;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign logic_res[gi] = Resta ? (x_op[gi] | B[gi])
                                         : (x_op[gi] & B[gi]);
        end
    endgenerate

    // Result and flags for the command presented this cycle; held values
    // are kept unless the command is accepted.
    always_comb begin
        result_d = result_q;
        cero_d   = cero_q;
        neg_d    = neg_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        if (accept) begin
            if (OP1) begin
                result_d = logic_res;
                cero_d   = 1'b0;
                neg_d    = 1'b0;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
            end else begin
                result_d = sum;
                cero_d   = (sum == '0);
                // Additions never report a negative result.
                neg_d    = sum[WIDTH-1] & Resta;
                cout_d   = carry[WIDTH];
                ovf_d    = carry[WIDTH] ^ carry[WIDTH-1];
            end
            acc_d = result_d;
        end
    end

    // out_valid: set by an accept, cleared by a drain without a new accept.
    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Sticky status and overflow counter: clear first, then let an event
    // accepted on the same edge win over the clear.
    always_comb begin
        sovf_d  = sovf_q;
        scout_d = scout_q;
        cnt_d   = cnt_q;
        if (clr_sticky) begin
            sovf_d  = 1'b0;
            scout_d = 1'b0;
            cnt_d   = '0;
        end
        if (accept) begin
            sovf_d  = sovf_d | ovf_d;
            scout_d = scout_d | cout_d;
            if (ovf_d && (cnt_d != {CNT_W{1'b1}})) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    // Output stage and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
            cero_q   <= 1'b0;
            neg_q    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
            cero_q   <= cero_d;
            neg_q    <= neg_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Sticky flags and event counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sovf_q  <= 1'b0;
            scout_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sovf_q  <= sovf_d;
            scout_q <= scout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign Result      = result_q;
    assign Cero        = cero_q;
    assign Negativo    = neg_q;
    assign C_out       = cout_q;
    assign Overflow    = ovf_q;
    assign sticky_ovf  = sovf_q;
    assign sticky_cout = scout_q;
    assign ovf_count   = cnt_q;

endmodule

// File: tb/tb_sumrest_flags_pipe.sv
// Testbench for sumrest_flags_pipe: directed scenarios followed by random
// traffic, all compared against a behavioural model using signed arithmetic.
module tb_sumrest_flags_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Resta;
    logic             OP1;
    logic             Acc_en;
    logic             clr_sticky;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Cero;
    logic             Negativo;
    logic             C_out;
    logic             Overflow;
    logic             sticky_ovf;
    logic             sticky_cout;
    logic [CNT_W-1:0] ovf_count;

    sumrest_flags_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Resta(Resta), .OP1(OP1), .Acc_en(Acc_en),
        .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Cero(Cero), .Negativo(Negativo),
        .C_out(C_out), .Overflow(Overflow),
        .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout),
        .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int m_acc, m_res, m_cnt;
    bit m_z, m_n, m_c, m_v, m_valid, m_so, m_sc;
    int ntx = 0;

    function automatic bit msb(input int v);
        return ((v >> (WIDTH - 1)) & 1) != 0;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_res = 0; m_cnt = 0;
        m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_valid = 0; m_so = 0; m_sc = 0;
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic model_edge();
        int x, b, s, mask;
        bit rdy, acc;
        mask = (1 << WIDTH) - 1;
        rdy  = !m_valid || out_ready;
        acc  = in_valid && rdy;
        if (clr_sticky) begin
            m_so = 0; m_sc = 0; m_cnt = 0;
        end
        if (acc) begin
            x = Acc_en ? m_acc : int'(A);
            b = int'(B);
            if (OP1) begin
                m_res = Resta ? (x | b) : (x & b);
                m_z = 0; m_n = 0; m_c = 0; m_v = 0;
            end else begin
                if (Resta) begin
                    s   = x + ((~b) & mask) + 1;
                    m_v = (msb(x) != msb(b)) && (msb(s & mask) != msb(x));
                end else begin
                    s   = x + b;
                    m_v = (msb(x) == msb(b)) && (msb(s & mask) != msb(x));
                end
                m_res = s & mask;
                m_c   = s > mask;
                m_z   = m_res == 0;
                m_n   = msb(m_res) && Resta;
            end
            m_acc   = m_res;
            m_valid = 1;
            m_so    = m_so | m_v;
            m_sc    = m_sc | m_c;
            if (m_v && m_cnt < CMAX) m_cnt++;
            ntx++;
            $display("tx %0d: A=%02h B=%02h Resta=%0b OP1=%0b Acc_en=%0b -> Result=%02h",
                     ntx, A, B, Resta, OP1, Acc_en, m_res);
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all(input string p);
        check({p, "_out_valid"},   32'(out_valid),   32'(m_valid));
        check({p, "_in_ready"},    32'(in_ready),    32'(!m_valid || out_ready));
        check({p, "_Result"},      32'(Result),      32'(m_res));
        check({p, "_Cero"},        32'(Cero),        32'(m_z));
        check({p, "_Negativo"},    32'(Negativo),    32'(m_n));
        check({p, "_C_out"},       32'(C_out),       32'(m_c));
        check({p, "_Overflow"},    32'(Overflow),    32'(m_v));
        check({p, "_sticky_ovf"},  32'(sticky_ovf),  32'(m_so));
        check({p, "_sticky_cout"}, 32'(sticky_cout), 32'(m_sc));
        check({p, "_ovf_count"},   32'(ovf_count),   32'(m_cnt));
    endtask

    task automatic step(input string p);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(p);
    endtask

    task automatic cmd(input logic [7:0] a, input logic [7:0] b,
                       input logic rs, input logic op, input logic ae,
                       input logic clr, input string p);
        in_valid = 1; A = a; B = b; Resta = rs; OP1 = op; Acc_en = ae;
        clr_sticky = clr;
        step(p);
        in_valid = 0; clr_sticky = 0; Acc_en = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; A = 0; B = 0; Resta = 0; OP1 = 0;
        Acc_en = 0; clr_sticky = 0; out_ready = 1;
        model_reset();
        #12;
        compare_all("reset");
        reset = 0;

        // Add with signed overflow
        cmd(8'h7F, 8'h01, 0, 0, 0, 0, "add_ovf");
        check("tp_add_ovf_res", 32'(Result), 32'h80);
        check("tp_add_ovf_cnt", 32'(ovf_count), 32'd1);
        // Subtraction to zero, then negative result
        cmd(8'h05, 8'h05, 1, 0, 0, 0, "sub_zero");
        check("tp_sub_zero_cero", 32'(Cero), 32'd1);
        cmd(8'h03, 8'h05, 1, 0, 0, 0, "sub_neg");
        check("tp_sub_neg_res", 32'(Result), 32'hFE);
        // Logic ops
        cmd(8'hF0, 8'h3C, 0, 1, 0, 0, "and");
        check("tp_and_res", 32'(Result), 32'h30);
        cmd(8'hF0, 8'h3C, 1, 1, 0, 0, "or");
        check("tp_or_res", 32'(Result), 32'hFC);
        step("drain");

        // Backpressure: three commands presented while downstream stalls
        out_ready = 0;
        cmd(8'h11, 8'h22, 0, 0, 0, 0, "bp0");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; A = 8'(8'h40 + i); B = 8'h01; Resta = 0; OP1 = 0;
            step("bp_hold");
            check("tp_bp_held", 32'(Result), 32'h33);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            A = 8'(8'h50 + i);
            step("bp_drain");
        end
        in_valid = 0;
        step("bp_idle");

        // Accumulate chain
        cmd(8'h10, 8'h00, 0, 0, 0, 0, "acc0");
        for (int i = 0; i < 3; i++) cmd(8'hAA, 8'h01, 0, 0, 1, 0, "acc");
        check("tp_acc_res", 32'(Result), 32'h13);

        // Saturating counter, then clear coinciding with an overflow
        clr_sticky = 1; step("clr"); clr_sticky = 0;
        for (int i = 0; i < 4; i++) cmd(8'h7F, 8'h01, 0, 0, 0, 0, "sat");
        check("tp_sat_cnt", 32'(ovf_count), 32'(CMAX));
        cmd(8'h80, 8'h80, 0, 0, 0, 1, "clr_ovf");
        check("tp_clr_ovf_cnt", 32'(ovf_count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            A          = 8'($urandom);
            B          = 8'($urandom);
            Resta      = 1'($urandom);
            OP1        = ($urandom_range(0, 3) == 0);
            Acc_en     = 1'($urandom);
            clr_sticky = ($urandom_range(0, 19) == 0);
            step("rnd");
        end
        in_valid = 0; clr_sticky = 0;

        // Asynchronous reset while a result is held
        out_ready = 0;
        cmd(8'h7F, 8'h7F, 0, 0, 0, 0, "pre_rst");
        #2;
        reset = 1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset = 0;
        out_ready = 1;
        cmd(8'h01, 8'h02, 0, 0, 1, 0, "post_rst");
        check("tp_post_rst_res", 32'(Result), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
